// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared definitions for the single-port SRAM arbiter slice.
//   - default address/data widths
//   - requester index constants
//   - FSM state encoding (IDLE, WRITE, READ, TURN)
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_TURN  = 2'd3;

  // A write accepted while the bus is in a read cycle needs a dead cycle
  // so the SRAM can release mem_data before this side drives it.
  function automatic logic needs_turn(input state_t cur, input logic is_write);
    return is_write && (cur == ST_READ);
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// sram_rr_arb: 2-way arbiter for the SRAM front end.
//   clk, rst_n : clock, synchronous active-low reset
//   elig       : eligible-request mask (bit REQ0 / bit REQ1)
//   advance    : the FSM accepts a command this cycle
//   win        : one-hot winner (combinational, zero when elig is zero)
// Build option: SRAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
// always wins a conflict, no fairness state); undefined gives round-robin.
module sram_rr_arb
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  input  logic       advance,
  output logic [1:0] win
);

`ifdef SRAM_ARB_FIXED_PRIO_EN

  always_comb begin
    win = 2'b00;
    if (elig[REQ0])      win[REQ0] = 1'b1;
    else if (elig[REQ1]) win[REQ1] = 1'b1;
  end

  // Clock, reset and advance only matter for the round-robin build.
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst_n, advance};

`else

  // 1 = requester 1 won last, so requester 0 wins the next conflict.
  logic last_grant;

  always_comb begin
    win = elig;
    if (elig == 2'b11) begin
      win = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance && (|elig)) begin
      last_grant <= win[REQ1];
    end
  end

`endif

endmodule

// File: rtl/sram_sp_arbiter.sv
// sram_sp_arbiter: two-requester front end for a single-port SRAM.
//   clk, rst_n            : clock, synchronous active-low reset
//   req/we/addr/wdata 0,1 : requester commands, req held until granted
//   gnt0/gnt1             : one-cycle pulse, command accepted
//   rvalid0/rvalid1       : one-cycle pulse, rdata valid for that requester
//   rdata                 : shared read data
//   mem_w_r/mem_addr      : SRAM control (1 = write)
//   mem_data              : bidirectional SRAM data, driven only in WRITE
// Build option: SRAM_ARB_FIXED_PRIO_EN (see sram_rr_arb).
// All outputs are registered; the state register describes the bus cycle
// currently on the SRAM pins.
module sram_sp_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_w_r,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  state_t            state;
  logic [1:0]        elig;
  logic [1:0]        win;
  logic              accept;
  logic              cmd_req;   // requester owning the current bus cycle
  logic              drive;
  logic [DATA_W-1:0] wdata_q;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A request is masked during its own grant pulse, which is what limits
  // one requester to an access every other cycle.
  assign elig   = {req1 & ~gnt1, req0 & ~gnt0};
  assign accept = (state != ST_TURN) && (|elig);

  sram_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .elig    (elig),
    .advance (accept),
    .win     (win)
  );

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (win[REQ1]) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  assign mem_data = drive ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mem_w_r  <= 1'b0;
      mem_addr <= '0;
      drive    <= 1'b0;
      wdata_q  <= '0;
      cmd_req  <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
    end else begin
      gnt0    <= accept & win[REQ0];
      gnt1    <= accept & win[REQ1];
      rvalid0 <= (state == ST_READ) & ~cmd_req;
      rvalid1 <= (state == ST_READ) &  cmd_req;
      if (state == ST_READ) begin
        rdata <= mem_data;
      end

      if (state == ST_TURN) begin
        // Address and data were latched on acceptance; only the bus
        // direction changes here.
        state   <= ST_WRITE;
        mem_w_r <= 1'b1;
        drive   <= 1'b1;
      end else if (accept) begin
        cmd_req  <= win[REQ1];
        mem_addr <= sel_addr;
        wdata_q  <= sel_wdata;
        if (needs_turn(state, sel_we)) begin
          state   <= ST_TURN;
          mem_w_r <= 1'b0;
          drive   <= 1'b0;
        end else if (sel_we) begin
          state   <= ST_WRITE;
          mem_w_r <= 1'b1;
          drive   <= 1'b1;
        end else begin
          state   <= ST_READ;
          mem_w_r <= 1'b0;
          drive   <= 1'b0;
        end
      end else begin
        state   <= ST_IDLE;
        mem_w_r <= 1'b0;
        drive   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// tb_sram_sp_arbiter: bench for sram_sp_arbiter with a behavioural SRAM,
// a transaction-level reference model and a grant-driven scoreboard.
module tb_sram_sp_arbiter;

  localparam int TR = 8192;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_w_r;
  logic [7:0] rdata;
  logic [3:0] mem_addr;
  wire  [7:0] mem_data;

  logic [7:0] sram [16];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  cmd_t q0[$];
  cmd_t q1[$];

  // reference model state
  logic [7:0] mm [16];
  bit         rv_pend = 0;
  bit         rv_req = 0;
  logic [7:0] rv_data = '0;
  bit         wr_pend = 0;
  cmd_t       wp;
  bit         prev_read = 0;

  // per-cycle trace of DUT outputs
  logic       tr_w   [TR];
  logic [3:0] tr_a   [TR];
  logic [7:0] tr_d   [TR];
  logic [1:0] tr_g   [TR];
  logic       tr_rv1 [TR];
  logic [7:0] tr_rd  [TR];

  sram_sp_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .mem_w_r  (mem_w_r),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // behavioural SRAM: drives the bus whenever it is not being written
  assign mem_data = (!mem_w_r) ? sram[mem_addr] : 8'hzz;

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_w_r) sram[mem_addr] <= mem_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one command, holds req until the grant pulse is seen and
  // returns the grant cycle (-1 on timeout).
  task automatic req_cmd(input int n, input logic we, input logic [3:0] a,
                         input logic [7:0] d, output int gcyc);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d;
    if (n == 0) begin
      q0.push_back(c); req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      q1.push_back(c); req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
    gcyc = -1;
    for (int i = 0; i < 64; i++) begin
      wait_cyc();
      if ((n == 0 && gnt0 === 1'b1) || (n == 1 && gnt1 === 1'b1)) begin
        gcyc = cyc;
        break;
      end
    end
    if (n == 0) req0 = 1'b0;
    else        req1 = 1'b0;
    if (gcyc < 0) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  // Monitor / scoreboard: each grant pops the requester's command and
  // predicts the bus cycle, the read result and its rvalid one cycle later.
  initial begin
    cmd_t c;
    bit   op_read;
    bit   n;
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (cyc < TR) begin
        tr_w[cyc] = mem_w_r; tr_a[cyc] = mem_addr; tr_d[cyc] = mem_data;
        tr_g[cyc] = {gnt1, gnt0}; tr_rv1[cyc] = rvalid1; tr_rd[cyc] = rdata;
      end
      if (rv_pend) begin
        chk(rv_req ? "rvalid1" : "rvalid0", rv_req ? rvalid1 : rvalid0, 1);
        chk("rvalid_other", rv_req ? rvalid0 : rvalid1, 0);
        chk("rdata", rdata, rv_data);
        rv_pend = 0;
      end else if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
        chk("unexpected_rvalid", {rvalid1, rvalid0}, 0);
      end
      op_read = 0;
      if (wr_pend) begin
        chk("turn_write_w_r", mem_w_r, 1);
        chk("turn_write_addr", mem_addr, wp.addr);
        chk("turn_write_data", mem_data, wp.data);
        chk("turn_write_no_gnt", {gnt1, gnt0}, 0);
        mm[wp.addr] = wp.data;
        wr_pend = 0;
      end else if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
        chk("double_gnt", 2'b11, 2'b00);
      end else if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        n = gnt1;
        if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
          chk("spurious_gnt", {gnt1, gnt0}, 0);
        end else begin
          if (n == 0) c = q0.pop_front();
          else        c = q1.pop_front();
          if (c.we) begin
            if (prev_read) begin
              chk("turn_w_r", mem_w_r, 0);
              wr_pend = 1;
              wp = c;
            end else begin
              chk("wr_w_r", mem_w_r, 1);
              chk("wr_addr", mem_addr, c.addr);
              chk("wr_data", mem_data, c.data);
              mm[c.addr] = c.data;
            end
          end else begin
            chk("rd_w_r", mem_w_r, 0);
            chk("rd_addr", mem_addr, c.addr);
            rv_pend = 1; rv_req = n; rv_data = mm[c.addr];
            op_read = 1;
          end
        end
      end else if (mem_w_r === 1'b1) begin
        chk("unexpected_write", mem_w_r, 0);
      end
      prev_read = op_read;
      if (rst_n === 1'b0) begin
        rv_pend = 0; wr_pend = 0; prev_read = 0;
      end
    end
  end

  initial begin
    int c, g0, g1, gx, gt0, gt1, holes, alt_bad, last, t;
    int ga [6];
    int gb [6];
    logic [1:0] prevg;

    // reset held with a pending request
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 8'h55;
    for (int i = 0; i < 3; i++) begin
      wait_cyc();
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_rvalid", {rvalid1, rvalid0}, 0);
      chk("rst_w_r", mem_w_r, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_rdata", rdata, 0);
    end
    req0 = 1'b0; rst_n = 1'b1;
    wait_cyc(2);

    // single write then read
    c = cyc;
    req_cmd(0, 1'b1, 4'd11, 8'h06, g0);
    chk("wr_latency", g0, c + 1);
    chk("wr_bus_w_r", mem_w_r, 1);
    chk("wr_bus_addr", mem_addr, 11);
    chk("wr_bus_data", mem_data, 8'h06);
    wait_cyc();
    c = cyc;
    req_cmd(0, 1'b0, 4'd11, 8'h00, g0);
    chk("rd_gnt_latency", g0, c + 1);
    wait_cyc();
    chk("rd_rvalid0", rvalid0, 1);
    chk("rd_rdata", rdata, 8'h06);

    // conflict from reset
    wait_cyc(2);
    rst_n = 1'b0; wait_cyc(2); rst_n = 1'b1;
    c = cyc;
    fork
      req_cmd(0, 1'b1, 4'd3, 8'h0F, g0);
      req_cmd(1, 1'b1, 4'd0, 8'h0A, g1);
    join
    chk("conf1_req0", g0, c + 1);
    chk("conf1_req1", g1, c + 2);
    wait_cyc(2);
    req_cmd(0, 1'b0, 4'd0, 8'h00, gx);
    wait_cyc(2);
    chk("conf_rd_addr0", tr_rd[gx + 1], 8'h0A);
    c = cyc;
    fork
      req_cmd(0, 1'b1, 4'd3, 8'h0F, g0);
      req_cmd(1, 1'b1, 4'd0, 8'h0A, g1);
    join
`ifdef SRAM_ARB_FIXED_PRIO_EN
    chk("conf2_req0", g0, c + 1);
    chk("conf2_req1", g1, c + 2);
`else
    chk("conf2_req1", g1, c + 1);
    chk("conf2_req0", g0, c + 2);
`endif

    // read followed by write needs a turnaround cycle
    wait_cyc(2);
    c = cyc;
    fork
      req_cmd(1, 1'b0, 4'd3, 8'h00, g1);
      begin
        wait_cyc();
        req_cmd(0, 1'b1, 4'd3, 8'h04, g0);
      end
    join
    wait_cyc(3);
    chk("ta_rd_gnt", g1, c + 1);
    chk("ta_wr_gnt", g0, c + 2);
    chk("ta_turn_w_r", tr_w[c + 2], 0);
    chk("ta_rvalid1", tr_rv1[c + 2], 1);
    chk("ta_rdata", tr_rd[c + 2], 8'h0F);
    chk("ta_write_w_r", tr_w[c + 3], 1);
    chk("ta_write_addr", tr_a[c + 3], 3);
    chk("ta_write_data", tr_d[c + 3], 8'h04);
    req_cmd(1, 1'b0, 4'd3, 8'h00, g1);
    wait_cyc(2);
    chk("ta_readback_rv", tr_rv1[g1 + 1], 1);
    chk("ta_readback", tr_rd[g1 + 1], 8'h04);

    // back-to-back: requesters re-present immediately after each grant
    wait_cyc(2);
    c = cyc;
    fork
      begin
        for (int i = 0; i < 6; i++) req_cmd(0, 1'b1, 4'(i + 4), 8'(8'h30 + i), ga[i]);
      end
      begin
        for (int j = 0; j < 6; j++) req_cmd(1, 1'b0, 4'(j + 4), 8'h00, gb[j]);
      end
    join
    wait_cyc(3);
    chk("b2b_first", (ga[0] < gb[0]) ? ga[0] : gb[0], c + 1);
    last = (ga[5] > gb[5]) ? ga[5] : gb[5];
    holes = 0; alt_bad = 0; prevg = 2'b00;
    for (t = c + 1; t <= last; t++) begin
      if (tr_g[t] == 2'b00 && tr_w[t] !== 1'b1) holes++;
      if (tr_g[t] != 2'b00) begin
        if (tr_g[t] == prevg) alt_bad++;
        prevg = tr_g[t];
      end
    end
    chk("b2b_bus_busy", holes, 0);
    chk("b2b_alternate", alt_bad, 0);

    // randomized traffic, checked by the scoreboard
    wait_cyc(2);
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          req_cmd(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), gt0);
          repeat ($urandom_range(0, 2)) wait_cyc();
        end
      end
      begin
        for (int j = 0; j < 150; j++) begin
          req_cmd(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), gt1);
          repeat ($urandom_range(0, 2)) wait_cyc();
        end
      end
    join

    // reset during a read cycle drops the rvalid
    wait_cyc(3);
    req_cmd(0, 1'b1, 4'd11, 8'hA5, g0);
    wait_cyc();
    req_cmd(0, 1'b0, 4'd11, 8'h00, g0);
    wait_cyc();
    chk("pre_rst_rdata", rdata, 8'hA5);
    req_cmd(0, 1'b0, 4'd11, 8'h00, g0);
    rst_n = 1'b0;
    wait_cyc();
    rst_n = 1'b1;
    chk("midrst_rvalid", {rvalid1, rvalid0}, 0);
    chk("midrst_gnt", {gnt1, gnt0}, 0);
    chk("midrst_w_r", mem_w_r, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_rdata", rdata, 0);

    wait_cyc(3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("no_pending_read", rv_pend, 0);
    chk("no_pending_write", wr_pend, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_sp_arbiter.md
Name: sram_sp_arbiter

Overview:
Two-port front end for the single-port SRAM (4-bit address, 8-bit bidirectional data, w_r=1 write / w_r=0 read).
- Arbitrates between two requesters with round-robin priority.
- Sequences each granted access onto the SRAM bus.
- Owns the tristate `mem_data` driver and inserts a bus-turnaround cycle between a read and a following write.

Parameters:
- ADDR_W, 4, SRAM address width.
- DATA_W, 8, SRAM data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- req0 / req1  input  1  access request, held high until granted.
- we0 / we1  input  1  1 = write, 0 = read; valid while reqN high.
- addr0 / addr1  input  ADDR_W  access address.
- wdata0 / wdata1  input  DATA_W  write data.
- gnt0 / gnt1  output  1  one-cycle pulse: command accepted.
- rvalid0 / rvalid1  output  1  one-cycle pulse: rdata holds read result for that requester.
- rdata  output  DATA_W  read data, shared by both requesters.
- mem_w_r  output  1  SRAM write/read select.
- mem_addr  output  ADDR_W  SRAM address.
- mem_data  inout  DATA_W  SRAM data bus; driven only in WRITE, otherwise Z.

Behaviour:
- States: IDLE, WRITE, READ, TURN; all outputs registered.
- Reset values: state=IDLE, mem_w_r=0, mem_addr=0, mem_data=Z, gnt0/1=0, rvalid0/1=0, rdata=0, last_grant=1 (requester 0 wins the first conflict).
- Eligibility: reqN is eligible only if gntN is low in that cycle. The pulse cycle masks the just-granted request.
- Acceptance: at the end of any IDLE, WRITE or READ cycle, if an eligible request exists, the arbiter:
  - picks the winner;
  - latches its we, addr and wdata;
  - updates last_grant;
  - pulses gntN in the next cycle.
- Arbitration: single eligible request wins. If both are eligible, the requester != last_grant wins.
- Next state after acceptance:
  - write accepted from READ -> TURN, then WRITE;
  - write otherwise -> WRITE;
  - read -> READ;
  - no acceptance -> IDLE.
- TURN: one cycle, mem_w_r=0, mem_data=Z. gnt pulses here. No new acceptance in TURN; always -> WRITE.
- WRITE cycle: mem_w_r=1, mem_addr=latched addr, mem_data=latched wdata. The SRAM commits at the closing edge.
- READ cycle: mem_w_r=0, mem_addr=latched addr, mem_data=Z. mem_data is sampled at the closing edge into rdata. rvalidN pulses the following cycle.
- IDLE: mem_w_r=0, mem_data=Z, mem_addr holds its last value.
- Latency, request seen in IDLE at cycle n:
  - gnt and the SRAM access occur in cycle n+1;
  - read data (rvalid) arrives in cycle n+2;
  - write after read: access in n+2.
- Throughput:
  - aggregate: 1 access/cycle (minus turnaround);
  - per requester: at most 1 access every 2 cycles.
- A write followed by a read never needs turnaround.
- Read data width equals DATA_W; no arithmetic.
- Reset mid-operation: on the next edge everything returns to reset values. The in-flight rvalid is dropped, the bus is released immediately, and a granted but unexecuted write is discarded.

Optional Feature:
- SRAM_ARB_FIXED_PRIO_EN defined: requester 0 always wins a conflict; last_grant is not used. Starvation of requester 1 is permitted.
- Undefined: round-robin as above.

Decomposition:
- Shared package sram_arb_pkg holds:
  - state enum (IDLE, WRITE, READ, TURN);
  - default ADDR_W=4 and DATA_W=8 constants;
  - requester index constants REQ0=0, REQ1=1.
- One natural sub-module, sram_rr_arb: a 2-way arbiter (eligible mask in, one-hot winner out, owns last_grant and the SRAM_ARB_FIXED_PRIO_EN switch).
- The FSM, command latch and tristate driver stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req0=1 -> gnt=0, rvalid=0, mem_w_r=0, mem_data=Z, mem_addr=0.
- Single write then read:
  - req0 write addr=11, data=8'h06 -> gnt0 next cycle, with mem_w_r=1, mem_addr=11, mem_data=8'h06 that cycle;
  - then req0 read addr=11 -> rvalid0 with rdata=8'h06 two cycles after request.
- Conflict: req0 and req1 both write (addr 3 = 8'h0F, addr 0 = 8'h0A) in the same cycle from reset -> gnt0 first, gnt1 next cycle. Repeating the conflict grants req1 first (round-robin). Under SRAM_ARB_FIXED_PRIO_EN, req0 first both times.
- Turnaround: req1 read addr 3 followed immediately by req0 write addr 3 = 8'h04 -> READ, TURN (mem_data=Z, mem_w_r=0), WRITE. rvalid1 carries 8'h0F; a later read of addr 3 returns 8'h04.
- Back-to-back: req0 write and req1 read held continuously -> bus busy every cycle, with grants alternating gnt0/gnt1.
- Reset mid-read: assert rst_n=0 in the READ cycle -> no rvalid pulse; outputs at reset values on the next edge.
